load_unit_misaligned: RTL

Sequential load unit that replaces pure combinational load alignment. It accepts one load request, issues one or two naturally aligned bus reads, and merges the data. It then byte-selects and sign- or zero-extends the result and returns it with a valid strobe. It sits between the multicycle control unit's load step and the memory/MMU read port, and is parametrised for RV32 or RV64 data width.

---
 rtl/load_unit_pkg.sv | 40 ++++
 rtl/load_extract.sv | 38 +++
 rtl/load_unit_misaligned.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/load_unit_pkg.sv
// Shared types and helpers for the sequential load unit and its extractor.
// Load op encodings follow the RISC-V load funct3 field.
package load_unit_pkg;

  localparam int unsigned LoadOpWidth = 3;

  localparam logic [LoadOpWidth-1:0] LoadOpLb  = 3'd0;
  localparam logic [LoadOpWidth-1:0] LoadOpLh  = 3'd1;
  localparam logic [LoadOpWidth-1:0] LoadOpLw  = 3'd2;
  localparam logic [LoadOpWidth-1:0] LoadOpLd  = 3'd3;
  localparam logic [LoadOpWidth-1:0] LoadOpLbu = 3'd4;
  localparam logic [LoadOpWidth-1:0] LoadOpLhu = 3'd5;
  localparam logic [LoadOpWidth-1:0] LoadOpLwu = 3'd6;

  typedef enum logic [1:0] {
    StIdle,
    StRd0,
    StRd1,
    StResp
  } state_e;

  // Access size in bytes; 0 marks an op that is illegal for this data width.
  function automatic logic [3:0] op_size(input logic [LoadOpWidth-1:0] op, input logic rv64);
    logic [3:0] sz;
    case (op)
      LoadOpLb, LoadOpLbu: sz = 4'd1;
      LoadOpLh, LoadOpLhu: sz = 4'd2;
      LoadOpLw:            sz = 4'd4;
      LoadOpLwu:           sz = rv64 ? 4'd4 : 4'd0;
      LoadOpLd:            sz = rv64 ? 4'd8 : 4'd0;
      default:             sz = 4'd0;
    endcase
    return sz;
  endfunction

  function automatic logic op_signed(input logic [LoadOpWidth-1:0] op);
    return (op == LoadOpLb) || (op == LoadOpLh) || (op == LoadOpLw);
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational byte select and sign/zero extension of a two-word window.
// Shared with the store/AMO path, so it stays free of any state.
module load_extract
  import load_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2*XLEN-1:0]          data_i,
  input  logic [$clog2(XLEN/8)-1:0]  off_i,
  input  logic [LoadOpWidth-1:0]     op_i,
  output logic [XLEN-1:0]            result_o
);

  logic [XLEN-1:0] val;
  logic [3:0]      sz;
  logic            sign_ext;
  logic            sign_bit;
  int              nbits;

  assign val      = XLEN'(data_i >> {off_i, 3'b000});
  assign sz       = op_size(op_i, XLEN == 64);
  assign sign_ext = op_signed(op_i);

  always_comb begin
    nbits    = int'(sz) * 8;
    sign_bit = 1'b0;
    result_o = '0;
    for (int i = 0; i < int'(XLEN); i++) begin
      if (i == nbits - 1) sign_bit = val[i];
    end
    for (int i = 0; i < int'(XLEN); i++) begin
      if (i < nbits) result_o[i] = val[i];
      else           result_o[i] = sign_ext & sign_bit;
    end
    if (nbits == 0) result_o = '0;
  end

endmodule

// File: rtl/load_unit_misaligned.sv
// Sequential load unit: one or two aligned bus reads per load, merged and extended.
// The result is registered on the way out of RESP, so rsp_valid trails RESP by one cycle.
module load_unit_misaligned
  import load_unit_pkg::*;
#(
  parameter int unsigned XLEN             = 32,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [31:0]            req_addr,
  input  logic [LoadOpWidth-1:0] req_op,
  output logic                   mem_valid,
  output logic [31:0]            mem_addr,
  input  logic                   mem_ready,
  input  logic [XLEN-1:0]        mem_rdata,
  output logic                   rsp_valid,
  output logic [XLEN-1:0]        rsp_data,
  output logic                   rsp_fault
);

  localparam int unsigned Bytes = XLEN / 8;
  localparam int unsigned OffW  = $clog2(Bytes);
  localparam bit          Rv64  = (XLEN == 64);

  state_e                 state_q, state_d;
  logic [LoadOpWidth-1:0] op_q, op_d;
  logic [OffW-1:0]        off_q, off_d;
  logic                   cross_q, cross_d;
  logic                   fault_q, fault_d;
  logic                   mem_valid_q, mem_valid_d;
  logic [31:0]            mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]        lo_q, lo_d;
  logic [XLEN-1:0]        hi_q, hi_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]        rsp_data_q, rsp_data_d;
  logic                   rsp_fault_q, rsp_fault_d;

  logic [3:0]      req_sz;
  logic [OffW-1:0] req_off;
  logic            req_cross;
  logic            req_misalign;
  logic            req_fault;
  logic [XLEN-1:0] extract_result;

  assign req_sz       = op_size(req_op, Rv64);
  assign req_off      = req_addr[OffW-1:0];
  assign req_cross    = (int'(req_off) + int'(req_sz)) > int'(Bytes);
  assign req_misalign = (32'(req_off) & (32'(req_sz) - 32'd1)) != 32'd0;
  assign req_fault    = (req_sz == 4'd0) || (!ALLOW_MISALIGNED && req_misalign);

  load_extract #(
    .XLEN(XLEN)
  ) u_extract (
    .data_i  ({hi_q, lo_q}),
    .off_i   (off_q),
    .op_i    (op_q),
    .result_o(extract_result)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    off_d       = off_q;
    cross_d     = cross_q;
    fault_d     = fault_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_fault_d = rsp_fault_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d       = req_op;
          off_d      = req_off;
          cross_d    = req_cross;
          mem_addr_d = {req_addr[31:OffW], {OffW{1'b0}}};
          lo_d       = '0;
          hi_d       = '0;
          if (req_fault) begin
            fault_d = 1'b1;
            state_d = StResp;
          end else begin
            fault_d     = 1'b0;
            mem_valid_d = 1'b1;
            state_d     = StRd0;
          end
        end
      end
      StRd0: begin
        if (mem_ready) begin
          lo_d = mem_rdata;
          if (cross_q) begin
            mem_addr_d = mem_addr_q + 32'(Bytes);
            state_d    = StRd1;
          end else begin
            mem_valid_d = 1'b0;
            state_d     = StResp;
          end
        end
      end
      StRd1: begin
        if (mem_ready) begin
          hi_d        = mem_rdata;
          mem_valid_d = 1'b0;
          state_d     = StResp;
        end
      end
      StResp: begin
        rsp_valid_d = 1'b1;
        rsp_fault_d = fault_q;
        rsp_data_d  = fault_q ? '0 : extract_result;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StIdle;
      op_q        <= '0;
      off_q       <= '0;
      cross_q     <= 1'b0;
      fault_q     <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      off_q       <= off_d;
      cross_q     <= cross_d;
      fault_q     <= fault_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_fault = rsp_fault_q;

endmodule
